// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_w_en,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last_id, last_id_nxt, grant_nxt;
    logic [IDW-1:0] pick, cand;
    logic [CW-1:0]  beat_cnt, beat_nxt;
    logic           found;

    // Search starts just past the previous grantee so it ends up with lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = last_id;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        fifo_w_en  = 1'b0;
        fifo_wdata = '0;
        if (state == GRANT) begin
            req_ready[grant_id] = !fifo_full;
            fifo_w_en           = req_valid[grant_id] & !fifo_full;
            fifo_wdata          = req_data[int'(grant_id)*WIDTH +: WIDTH];
        end
    end

    assign busy = (state == GRANT);

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_id;
        last_id_nxt = last_id;
        beat_nxt    = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    grant_nxt = pick;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (fifo_w_en) begin
                    beat_nxt = beat_cnt + 1'b1;
                end
                // Full alone never releases; only the burst limit or a finished producer does.
                if ((fifo_w_en && beat_cnt == LAST_BEAT) || !req_valid[grant_id]) begin
                    state_nxt   = IDLE;
                    last_id_nxt = grant_id;
                    beat_nxt    = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= LAST_IDX;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            last_id  <= last_id_nxt;
            beat_cnt <= beat_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized self-checking bench for fifo_wr_arbiter
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int NB = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_wdata;
    logic [1:0]     grant_id;
    logic           busy;

    logic [NB-1:0]   valid_b = '0;
    logic [NB*W-1:0] data_b;
    logic [NB-1:0]   ready_b;
    logic            w_en_b;
    logic [W-1:0]    wdata_b;
    logic [1:0]      grant_b;
    logic            busy_b;

    logic [W-1:0] pdata [N];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Reference model: who owns the port, beats taken, previous owner.
    int m_busy = 0, m_owner = 0, m_count = 0, m_last = N - 1;
    logic [N-1:0] exp_ready, obs_ready, acc;
    logic         exp_wen, obs_wen, exp_busy, obs_busy;
    logic [W-1:0] exp_wdata, obs_wdata;
    logic [1:0]   exp_grant, obs_grant;
    logic [15:0]  exp_vec, obs_vec;
    logic [W-1:0] wr_data [$];
    int           wr_cyc [$];

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
        .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(NB), .WIDTH(W), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_data(data_b),
        .req_ready(ready_b), .fifo_full(1'b0), .fifo_w_en(w_en_b),
        .fifo_wdata(wdata_b), .grant_id(grant_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = pdata[i];
    end

    assign data_b = {8'hB2, 8'hB1, 8'hB0};

    task automatic model_eval();
        exp_ready = '0;
        exp_wen   = 1'b0;
        exp_wdata = '0;
        exp_busy  = (m_busy != 0);
        exp_grant = 2'(m_owner);
        if (m_busy != 0) begin
            if (!fifo_full) exp_ready[m_owner] = 1'b1;
            exp_wen   = req_valid[m_owner] && !fifo_full;
            exp_wdata = pdata[m_owner];
        end
        exp_vec = {exp_ready, exp_wen, exp_wdata, exp_busy, exp_grant};
    endtask

    task automatic model_commit();
        if (rst) begin
            m_busy = 0; m_owner = 0; m_count = 0; m_last = N - 1;
        end else if (m_busy == 0) begin
            for (int d = 1; d <= N; d++) begin
                if (req_valid[(m_last + d) % N]) begin
                    m_owner = (m_last + d) % N;
                    m_busy  = 1;
                    m_count = 0;
                    break;
                end
            end
        end else if (exp_wen) begin
            m_count++;
            if (m_count == MB) begin
                m_busy = 0; m_last = m_owner;
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 0; m_last = m_owner;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        obs_ready = req_ready;
        obs_wen   = fifo_w_en;
        obs_wdata = fifo_wdata;
        obs_busy  = busy;
        obs_grant = grant_id;
        obs_vec   = {obs_ready, obs_wen, obs_wdata, obs_busy, obs_grant};
        acc       = req_ready & req_valid;
        if (fifo_w_en) begin
            wr_data.push_back(fifo_wdata);
            wr_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; valid_b = '0; fifo_full = 1'b0;
        step();
        rst = 1'b0;
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) pdata[i] = 8'h5A;
        step();
        step();
        total_cnt++;
        if (obs_vec !== 16'h0) $display("FAIL reset_held got %h expected 0000", obs_vec);
        else pass_cnt++;
        rst = 1'b0; req_valid = '0;
        step();
        total_cnt++;
        if (obs_vec !== 16'h0) $display("FAIL reset_release got %h expected 0000", obs_vec);
        else pass_cnt++;
        total_cnt++;
        if ({busy_b, w_en_b, ready_b, wdata_b} !== '0)
            $display("FAIL reset_b got %b expected all zero", {busy_b, w_en_b, ready_b, wdata_b});
        else pass_cnt++;
    endtask

    task automatic test_single_stream();
        int sent = 0;
        do_reset();
        pdata[0] = 8'hA0; req_valid = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            step();
            total_cnt++;
            if (obs_vec !== exp_vec) $display("FAIL single_model cyc=%0d got %h expected %h", cyc, obs_vec, exp_vec);
            else pass_cnt++;
            if (c == 1) begin
                total_cnt++;
                if (!(obs_busy === 1'b1 && obs_grant === 2'd0))
                    $display("FAIL single_grant busy=%b gid=%0d expected busy=1 gid=0", obs_busy, obs_grant);
                else pass_cnt++;
            end
            if (acc[0]) begin
                sent++;
                if (sent == 6) req_valid[0] = 1'b0;
                else pdata[0] = 8'(8'hA0 + sent);
            end
        end
        total_cnt++;
        if (wr_data.size() != 6) $display("FAIL single_count got %0d expected 6", wr_data.size());
        else begin
            int bad = 0;
            for (int i = 0; i < 6; i++) if (wr_data[i] !== 8'(8'hA0 + i)) bad++;
            if (bad != 0 || wr_cyc[4] - wr_cyc[3] != 2 || wr_cyc[3] - wr_cyc[0] != 3)
                $display("FAIL single_order bad=%0d gap=%0d expected bad=0 gap=2", bad, wr_cyc[4] - wr_cyc[3]);
            else pass_cnt++;
        end
    endtask

    task automatic test_all_valid();
        int beats [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            beats[i] = 0; pdata[i] = 8'(16 * i);
        end
        req_valid = '1;
        for (int c = 0; c < 60 && wr_data.size() < 20; c++) begin
            step();
            total_cnt++;
            if (obs_vec !== exp_vec) $display("FAIL all_model cyc=%0d got %h expected %h", cyc, obs_vec, exp_vec);
            else pass_cnt++;
            if (obs_busy) begin
                total_cnt++;
                if ($countones(obs_ready) != 1) $display("FAIL all_onehot got %b expected one bit", obs_ready);
                else pass_cnt++;
            end
            for (int i = 0; i < N; i++) if (acc[i]) begin
                beats[i]++; pdata[i] = 8'(16 * i + beats[i]);
            end
        end
        total_cnt++;
        if (wr_data.size() != 20) $display("FAIL all_count got %0d expected 20", wr_data.size());
        else begin
            int bad = 0;
            for (int n = 0; n < 20; n++)
                if (wr_data[n] !== 8'(16 * ((n / 4) % 4) + 4 * (n / 16) + n % 4)) bad++;
            if (bad != 0) $display("FAIL all_order got %0d wrong beats expected 0", bad);
            else pass_cnt++;
        end
    endtask

    task automatic test_release_on_drop();
        int sent = 0;
        do_reset();
        pdata[2] = 8'h55; req_valid = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            step();
            total_cnt++;
            if (obs_vec !== exp_vec) $display("FAIL drop_model cyc=%0d got %h expected %h", cyc, obs_vec, exp_vec);
            else pass_cnt++;
            if (c == 4) begin
                total_cnt++;
                if (obs_busy !== 1'b0) $display("FAIL drop_release busy=%b expected 0", obs_busy);
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++;
                if (!(obs_busy === 1'b1 && obs_grant === 2'd3))
                    $display("FAIL drop_next gid=%0d busy=%b expected gid=3 busy=1", obs_grant, obs_busy);
                else pass_cnt++;
            end
            if (acc[2]) begin
                sent++;
                if (sent == 1) pdata[2] = 8'h66;
                else begin
                    req_valid = 4'b1001; pdata[3] = 8'h33; pdata[0] = 8'h0C;
                end
            end
        end
        total_cnt++;
        if (wr_data.size() < 2 || wr_data[0] !== 8'h55 || wr_data[1] !== 8'h66 || wr_cyc[1] - wr_cyc[0] != 1)
            $display("FAIL drop_data got size %0d expected 55,66 back to back", wr_data.size());
        else pass_cnt++;
    endtask

    task automatic test_full_stall();
        int sent = 0;
        do_reset();
        pdata[1] = 8'h70; req_valid = 4'b0010;
        for (int c = 0; c < 14; c++) begin
            step();
            total_cnt++;
            if (obs_vec !== exp_vec) $display("FAIL full_model cyc=%0d got %h expected %h", cyc, obs_vec, exp_vec);
            else pass_cnt++;
            if (c >= 2 && c <= 6) begin
                total_cnt++;
                if (obs_wen !== 1'b0 || obs_ready[1] !== 1'b0 || obs_grant !== 2'd1 || obs_busy !== 1'b1)
                    $display("FAIL full_hold cyc=%0d wen=%b ready=%b gid=%0d expected wen=0 ready=0 gid=1",
                             cyc, obs_wen, obs_ready, obs_grant);
                else pass_cnt++;
            end
            if (c == 10) begin
                total_cnt++;
                if (obs_busy !== 1'b0) $display("FAIL full_release busy=%b expected 0", obs_busy);
                else pass_cnt++;
            end
            if (acc[1]) begin
                sent++; pdata[1] = 8'(8'h70 + sent);
            end
            fifo_full = (c >= 1 && c <= 5);
        end
        total_cnt++;
        if (wr_data.size() < 4 || wr_data[0] !== 8'h70 || wr_data[1] !== 8'h71 ||
            wr_data[2] !== 8'h72 || wr_data[3] !== 8'h73 || wr_cyc[1] - wr_cyc[0] != 6)
            $display("FAIL full_data got size %0d expected 70..73 with 5-cycle stall", wr_data.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < N; i++) pdata[i] = 8'(8'h40 + i);
        req_valid = 4'b0010;
        for (int c = 0; c < 11; c++) begin
            step();
            total_cnt++;
            if (obs_vec !== exp_vec) $display("FAIL rstmid_model cyc=%0d got %h expected %h", cyc, obs_vec, exp_vec);
            else pass_cnt++;
            if (c == 9) begin
                total_cnt++;
                if (obs_busy !== 1'b0 || obs_ready !== 4'b0 || obs_wen !== 1'b0)
                    $display("FAIL rstmid_idle busy=%b ready=%b wen=%b expected all 0", obs_busy, obs_ready, obs_wen);
                else pass_cnt++;
            end
            if (c == 10) begin
                total_cnt++;
                if (!(obs_busy === 1'b1 && obs_grant === 2'd0))
                    $display("FAIL rstmid_regrant gid=%0d busy=%b expected gid=0 busy=1", obs_grant, obs_busy);
                else pass_cnt++;
            end
            rst = 1'b0;
            if (c == 4) req_valid = 4'b0100;
            if (c == 7) begin
                rst = 1'b1; req_valid = '1;
            end
        end
    endtask

    task automatic test_burst1();
        int g;
        do_reset();
        valid_b = '1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total_cnt++;
            if (k % 2 == 0) begin
                if (w_en_b !== 1'b0 || busy_b !== 1'b0 || ready_b !== 3'b0)
                    $display("FAIL burst1_gap k=%0d wen=%b busy=%b expected 0", k, w_en_b, busy_b);
                else pass_cnt++;
            end else begin
                g = ((k - 1) / 2) % NB;
                if (w_en_b !== 1'b1 || grant_b !== 2'(g) || wdata_b !== 8'(8'hB0 + g) || ready_b !== 3'(1 << g))
                    $display("FAIL burst1_write k=%0d gid=%0d data=%h expected gid=%0d data=%h",
                             k, grant_b, wdata_b, g, 8'(8'hB0 + g));
                else pass_cnt++;
            end
            @(posedge clk);
            #1;
        end
        valid_b = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N; i++) pdata[i] = 8'($urandom);
        req_valid = 4'($urandom);
        for (int c = 0; c < 400; c++) begin
            step();
            total_cnt++;
            if (obs_vec !== exp_vec) $display("FAIL random_model cyc=%0d got %h expected %h", cyc, obs_vec, exp_vec);
            else pass_cnt++;
            if (obs_wen && fifo_full) begin
                total_cnt++;
                $display("FAIL random_full_write cyc=%0d wen=1 expected 0 while full", cyc);
            end
            for (int i = 0; i < N; i++) if (acc[i]) pdata[i] = 8'($urandom);
            req_valid = 4'($urandom) | 4'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_all_valid();
        test_release_on_drop();
        test_full_stall();
        test_reset_mid_burst();
        test_burst1();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
